lane_mem_scan_accum: RTL and testbench

- Parametrised successor to the fixed 7-entry match/accumulate test block.
- Stores NLANES input lanes per enabled cycle into a circular DEPTH-entry register array, with a wrapping write pointer.
- An on-demand scan FSM walks every entry, one per cycle, and reports a saturating sum, a nonzero-entry count and a done pulse.
- Used as a regression DUT for memory/loop/task lowering, so all of its behaviour is cycle-exact.

---
 rtl/lane_mem_scan_accum.sv | 171 +++++++++++++++++
 tb/tb_lane_mem_scan_accum.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_mem_scan_accum.sv
// Circular multi-lane entry store with an on-demand scan that reports a
// saturating sum, a nonzero-entry count and a one-cycle done pulse.
module lane_mem_scan_accum #(
  parameter int WIDTH   = 10,
  parameter int ENTRY_W = 8,
  parameter int DEPTH   = 7,
  parameter int NLANES  = 4,
  parameter int SUM_W   = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [NLANES*WIDTH-1:0]    lane_data,
  input  logic                       scan_start,
  output logic                       busy,
  output logic                       done,
  output logic [SUM_W-1:0]           sum_out,
  output logic [$clog2(DEPTH+1)-1:0] nz_count,
  output logic                       sat,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW1   = PTR_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SX    = SUM_W + 1;
  localparam logic [PW1-1:0]   DEPTH_X  = PW1'(DEPTH);
  localparam logic [PW1-1:0]   NLANES_X = PW1'(NLANES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  logic [ENTRY_W-1:0] entry_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [DEPTH-1:0]   hit_vec;
  logic [ENTRY_W-1:0] wval_arr [DEPTH];

  // Each entry works out which lane (if any) lands on it from its distance
  // ahead of the write pointer, so no runtime modulo is needed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [PW1-1:0] GI = PW1'(gi);
    logic [PW1-1:0]     off;
    logic               hit;
    logic [ENTRY_W-1:0] wval;

    always_comb begin
      if (GI >= {1'b0, wr_ptr_reg}) begin
        off = GI - {1'b0, wr_ptr_reg};
      end else begin
        off = GI + DEPTH_X - {1'b0, wr_ptr_reg};
      end
      hit  = 1'b0;
      wval = '0;
      for (int k = 0; k < NLANES; k++) begin
        if (off == PW1'(k)) begin
          hit  = 1'b1;
          wval = lane_data[k*WIDTH +: ENTRY_W];
        end
      end
    end

    assign hit_vec[gi]  = hit;
    assign wval_arr[gi] = wval;
  end

  always_comb begin
    logic [PW1-1:0] ptr_sum;
    ptr_sum = {1'b0, wr_ptr_reg} + NLANES_X;
    if (ptr_sum >= DEPTH_X) begin
      ptr_sum = ptr_sum - DEPTH_X;
    end
    wr_ptr_next = ptr_sum[PTR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        entry_reg[e] <= '0;
      end
    end else if (enable) begin
      wr_ptr_reg <= wr_ptr_next;
      for (int e = 0; e < DEPTH; e++) begin
        if (hit_vec[e]) begin
          entry_reg[e] <= wval_arr[e];
        end
      end
    end
  end

  state_t             state_reg;
  logic [PTR_W-1:0]   idx_reg;
  logic [SUM_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sat_flag_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [SUM_W-1:0]   sum_out_reg;
  logic [CNT_W-1:0]   nz_count_reg;
  logic               sat_reg;

  logic [ENTRY_W-1:0] cur_entry;
  logic [SX-1:0]      acc_sum;
  logic [SUM_W-1:0]   acc_next;
  logic               sat_step;
  logic [CNT_W-1:0]   cnt_next;

  // One scan step: add the entry under idx and clamp at the accumulator max.
  always_comb begin
    cur_entry = entry_reg[idx_reg];
    acc_sum   = {1'b0, acc_reg} + SX'(cur_entry);
    sat_step  = acc_sum[SUM_W];
    acc_next  = sat_step ? '1 : acc_sum[SUM_W-1:0];
    cnt_next  = cnt_reg + CNT_W'(cur_entry != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      sat_flag_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sum_out_reg  <= '0;
      nz_count_reg <= '0;
      sat_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (scan_start) begin
            state_reg    <= SCAN;
            busy_reg     <= 1'b1;
            idx_reg      <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            sat_flag_reg <= 1'b0;
          end
        end
        SCAN: begin
          acc_reg      <= acc_next;
          cnt_reg      <= cnt_next;
          sat_flag_reg <= sat_flag_reg | sat_step;
          if (idx_reg == LAST_IDX) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            sum_out_reg  <= acc_next;
            nz_count_reg <= cnt_next;
            sat_reg      <= sat_flag_reg | sat_step;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign sum_out  = sum_out_reg;
  assign nz_count = nz_count_reg;
  assign sat      = sat_reg;
  assign wr_ptr   = wr_ptr_reg;

endmodule

// File: tb/tb_lane_mem_scan_accum.sv
// Scoreboard bench: a default build and a SUM_W=9 build run in lockstep.
module tb_lane_mem_scan_accum;
  localparam int WIDTH = 10, ENTRY_W = 8, DEPTH = 7, NLANES = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset, clear, enable, scan_start;
  logic [NLANES*WIDTH-1:0] lane_data;
  logic                    busy, done, sat, busy9, done9, sat9;
  logic [10:0]             sum_out;
  logic [8:0]              sum9;
  logic [2:0]              nz_count, nz9, wr_ptr, wr_ptr9;

  lane_mem_scan_accum dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .lane_data(lane_data), .scan_start(scan_start), .busy(busy), .done(done),
    .sum_out(sum_out), .nz_count(nz_count), .sat(sat), .wr_ptr(wr_ptr)
  );

  lane_mem_scan_accum #(.SUM_W(9)) dut9 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .lane_data(lane_data), .scan_start(scan_start), .busy(busy9), .done(done9),
    .sum_out(sum9), .nz_count(nz9), .sat(sat9), .wr_ptr(wr_ptr9)
  );

  typedef struct {
    logic [10:0] sum;
    logic        s;
    logic [8:0]  sum9;
    logic        s9;
    logic [2:0]  cnt;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [DEPTH];
  int         ptr_m;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
  endtask

  task automatic push_expected;
    exp_t e;
    int   total = 0;
    int   cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      total += int'(mem_m[i]);
      if (mem_m[i] != 8'h00) cnt++;
    end
    e.sum  = (total > 2047) ? 11'h7FF : 11'(total);
    e.s    = (total > 2047);
    e.sum9 = (total > 511) ? 9'h1FF : 9'(total);
    e.s9   = (total > 511);
    e.cnt  = 3'(cnt);
    q.push_back(e);
  endtask

  task automatic write_lanes(input logic [9:0] l0, l1, l2, l3);
    logic [9:0] ln [NLANES];
    ln = '{l0, l1, l2, l3};
    lane_data = {l3, l2, l1, l0};
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k < NLANES; k++) mem_m[(ptr_m + k) % DEPTH] = ln[k][7:0];
    ptr_m = (ptr_m + NLANES) % DEPTH;
    $display("write lanes %h %h %h %h -> wr_ptr %0d (model %0d)", l0, l1, l2, l3, wr_ptr, ptr_m);
    n_checks++;
    if (wr_ptr !== 3'(ptr_m)) begin
      n_fail++;
      $display("FAIL write_wr_ptr got %0d expected %0d", wr_ptr, ptr_m);
    end
  endtask

  task automatic start_scan;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int pre);
    exp_t e;
    int   busy_cycles = pre;
    int   n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout got done=%b expected 1", name, done);
    end
    n_checks++;
    if (busy_cycles != DEPTH) begin
      n_fail++;
      $display("FAIL %s_busy_cycles got %0d expected %0d", name, busy_cycles, DEPTH);
    end
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_queue got empty expected entry", name);
    end else begin
      e = q.pop_front();
      $display("scan %s: sum %h nz %0d sat %b sum9 %h sat9 %b (exp %h %0d %b %h %b)",
               name, sum_out, nz_count, sat, sum9, sat9, e.sum, e.cnt, e.s, e.sum9, e.s9);
      n_checks++;
      if (sum_out !== e.sum) begin
        n_fail++;
        $display("FAIL %s_sum got %h expected %h", name, sum_out, e.sum);
      end
      n_checks++;
      if (nz_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s_nz got %0d expected %0d", name, nz_count, e.cnt);
      end
      n_checks++;
      if (sat !== e.s) begin
        n_fail++;
        $display("FAIL %s_sat got %b expected %b", name, sat, e.s);
      end
      n_checks++;
      if (sum9 !== e.sum9 || sat9 !== e.s9 || done9 !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_sum9 got %h/%b/%b expected %h/%b/1", name, sum9, sat9, done9, e.sum9, e.s9);
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_width got %b expected 0", name, done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    $display("reset applied");
    n_checks++;
    if ({busy, done, sum_out, nz_count, sat, wr_ptr} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got %b/%b/%h/%0d/%b/%0d expected all 0",
               busy, done, sum_out, nz_count, sat, wr_ptr);
    end
    push_expected();
    start_scan();
    wait_done("reset_scan", 0);
  endtask

  task automatic test_write_scan;
    write_lanes(10'h3FF, 10'h101, 10'h0A5, 10'h000);
    push_expected();
    start_scan();
    wait_done("write_scan", 0);
  endtask

  task automatic test_wrap;
    write_lanes(10'h011, 10'h022, 10'h033, 10'h044);
    push_expected();
    start_scan();
    wait_done("wrap_scan", 0);
  endtask

  task automatic test_saturate;
    write_lanes(10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF);
    write_lanes(10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF);
    push_expected();
    start_scan();
    wait_done("sat_scan", 0);
  endtask

  task automatic test_reset_mid_scan;
    int dones = 0;
    start_scan();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    $display("reset in third scan cycle: busy %b sum %h done %b", busy, sum_out, done);
    n_checks++;
    if (busy !== 1'b0 || sum_out !== 11'h000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state got busy=%b sum=%h done=%b expected 0/000/0", busy, sum_out, done);
    end
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done got %0d pulses expected 0", dones);
    end
    write_lanes(10'h205, 10'h000, 10'h007, 10'h100);
    push_expected();
    start_scan();
    wait_done("after_reset_scan", 0);
  endtask

  task automatic test_clear_enable;
    lane_data = {10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD};
    clear = 1'b1;
    enable = 1'b1;
    tick();
    clear = 1'b0;
    enable = 1'b0;
    model_reset();
    $display("clear+enable -> wr_ptr %0d", wr_ptr);
    n_checks++;
    if (wr_ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_wr_ptr got %0d expected 0", wr_ptr);
    end
    push_expected();
    start_scan();
    wait_done("clear_scan", 0);
  endtask

  task automatic test_busy_restart;
    int pre = 0;
    int dones = 0;
    write_lanes(10'h010, 10'h020, 10'h030, 10'h040);
    push_expected();
    start_scan();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) scan_start = 1'b1;
      if (busy === 1'b1) pre++;
      tick();
      scan_start = 1'b0;
    end
    wait_done("busy_restart", pre);
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL busy_restart_extra got %0d active cycles expected 0", dones);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    enable = 1'b0;
    scan_start = 1'b0;
    lane_data = '0;
    model_reset();
    test_reset();
    test_write_scan();
    test_wrap();
    test_saturate();
    test_reset_mid_scan();
    test_clear_enable();
    test_busy_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
